imem: RTL and testbench

IMEM -- requirements
Module: imem

---
 rtl/imem.sv | 145 ++++++++++++++
 tb/tb_imem.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem.sv
// -----------------------------------------------------------------------------
// imem -- instruction memory with a fixed, parameterised read latency.
//
// A read request from the fetch stage is captured in IDLE, waits LATENCY
// cycles in WAIT and is answered with a single-cycle mem_rd_ready strobe in
// RESP. RESP always falls back to IDLE, which enforces one idle cycle between
// responses. Dropping mem_rd_enable while in WAIT aborts the request.
// Misaligned or out-of-range requests are answered with mem_rd_error=1 and
// zero data. A program-load write port updates the array on any edge,
// independent of the read FSM; a write and a read to the same word on the same
// edge return the old contents.
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   asynchronous, active-high
//   mem_rd_addr    in   byte address of the requested instruction
//   mem_rd_enable  in   read request, held until response or abort
//   mem_rd_data    out  instruction word, non-zero only in the RESP cycle
//   mem_rd_ready   out  one-cycle response strobe
//   mem_rd_error   out  qualifies mem_rd_ready: misaligned or out of range
//   mem_wr_enable  in   program-load write strobe
//   mem_wr_addr    in   byte address of the write (bits [1:0] ignored)
//   mem_wr_data    in   word to write
// -----------------------------------------------------------------------------
`ifndef ADDR_SIZE
`define ADDR_SIZE 31
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 31
`endif

module imem #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [`ADDR_SIZE:0]  mem_rd_addr,
    input  logic                 mem_rd_enable,
    output logic [`INSTR_SIZE:0] mem_rd_data,
    output logic                 mem_rd_ready,
    output logic                 mem_rd_error,
    input  logic                 mem_wr_enable,
    input  logic [`ADDR_SIZE:0]  mem_wr_addr,
    input  logic [`INSTR_SIZE:0] mem_wr_data
);

    localparam int AW = `ADDR_SIZE + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [`ADDR_SIZE:0] DEPTH_W = AW'(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [`ADDR_SIZE:0]   r_addr;
    logic                  r_ready;
    logic                  r_error;
    logic [`INSTR_SIZE:0]  r_data;
    logic [`INSTR_SIZE:0]  r_mem [0:DEPTH-1];

    logic [`ADDR_SIZE:0]   w_rd_addr;
    logic [`ADDR_SIZE:0]   w_rd_word;
    logic                  w_rd_err;
    logic [`INSTR_SIZE:0]  w_rd_val;
    logic [`ADDR_SIZE:0]   w_wr_word;
    logic                  w_wr_ok;
    logic                  w_unused_wr_lsb;

    // With LATENCY=0 the RESP entry happens on the capture edge itself, so the
    // lookup must come straight from the port while in IDLE.
    assign w_rd_addr = (r_state == IDLE) ? mem_rd_addr : r_addr;
    assign w_rd_word = {2'b00, w_rd_addr[`ADDR_SIZE:2]};
    assign w_rd_err  = (w_rd_addr[1:0] != 2'b00) || (w_rd_word >= DEPTH_W);
    assign w_rd_val  = w_rd_err ? '0 : r_mem[w_rd_word[IW-1:0]];

    assign w_wr_word = {2'b00, mem_wr_addr[`ADDR_SIZE:2]};
    assign w_wr_ok   = mem_wr_enable && (w_wr_word < DEPTH_W);
    assign w_unused_wr_lsb = ^mem_wr_addr[1:0];

    // Array has no reset so that program contents survive a core reset.
    // The nonblocking write makes a same-edge read see the old word.
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_mem[w_wr_word[IW-1:0]] <= mem_wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_data  <= '0;
        end else begin
            // Response outputs are only non-zero for the single RESP cycle.
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_data  <= '0;
            case (r_state)
                IDLE: begin
                    if (mem_rd_enable) begin
                        r_addr <= mem_rd_addr;
                        if (LATENCY == 0) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                            r_error <= w_rd_err;
                            r_data  <= w_rd_val;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    // Abort wins even on the edge that would have entered RESP.
                    if (!mem_rd_enable) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_error <= w_rd_err;
                        r_data  <= w_rd_val;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd_ready = r_ready;
    assign mem_rd_error = r_error;
    assign mem_rd_data  = r_data;

endmodule

// File: tb/tb_imem.sv
// -----------------------------------------------------------------------------
// tb_imem -- directed bench for imem. Three instances with DEPTH=16:
//   index 0: LATENCY=2, index 1: LATENCY=0, index 2: LATENCY=3.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_imem;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  rd_en;
    logic [2:0]  wr_en;
    logic [31:0] rd_addr [3];
    logic [31:0] wr_addr [3];
    logic [31:0] wr_data [3];
    logic [31:0] rd_data [3];
    logic [2:0]  rd_ready;
    logic [2:0]  rd_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem #(.DEPTH(16), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset),
        .mem_rd_addr(rd_addr[0]), .mem_rd_enable(rd_en[0]),
        .mem_rd_data(rd_data[0]), .mem_rd_ready(rd_ready[0]), .mem_rd_error(rd_error[0]),
        .mem_wr_enable(wr_en[0]), .mem_wr_addr(wr_addr[0]), .mem_wr_data(wr_data[0])
    );
    imem #(.DEPTH(16), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(reset),
        .mem_rd_addr(rd_addr[1]), .mem_rd_enable(rd_en[1]),
        .mem_rd_data(rd_data[1]), .mem_rd_ready(rd_ready[1]), .mem_rd_error(rd_error[1]),
        .mem_wr_enable(wr_en[1]), .mem_wr_addr(wr_addr[1]), .mem_wr_data(wr_data[1])
    );
    imem #(.DEPTH(16), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset),
        .mem_rd_addr(rd_addr[2]), .mem_rd_enable(rd_en[2]),
        .mem_rd_data(rd_data[2]), .mem_rd_ready(rd_ready[2]), .mem_rd_error(rd_error[2]),
        .mem_wr_enable(wr_en[2]), .mem_wr_addr(wr_addr[2]), .mem_wr_data(wr_data[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int k, input logic [31:0] a, input logic [31:0] d);
        wr_en[k]   = 1'b1;
        wr_addr[k] = a;
        wr_data[k] = d;
        tick();
        wr_en[k]   = 1'b0;
    endtask

    // Raise a request and advance n edges (first edge is the capture edge).
    task automatic issue(input int k, input logic [31:0] a, input int n);
        rd_addr[k] = a;
        rd_en[k]   = 1'b1;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd_ready[k] !== 1'b0) begin
                failures++; $display("FAIL reset_ready[%0d] got=%b exp=0", k, rd_ready[k]);
            end
            checks++;
            if (rd_error[k] !== 1'b0) begin
                failures++; $display("FAIL reset_error[%0d] got=%b exp=0", k, rd_error[k]);
            end
            checks++;
            if (rd_data[k] !== 32'h0) begin
                failures++; $display("FAIL reset_data[%0d] got=%h exp=0", k, rd_data[k]);
            end
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_latency2();
        do_write(0, 32'h4, 32'h0000_0013);
        issue(0, 32'h4, 1);                       // E0
        checks++;
        if (rd_ready[0] !== 1'b0) begin
            failures++; $display("FAIL l2_ready_e0 got=%b exp=0", rd_ready[0]);
        end
        tick();                                   // E1
        checks++;
        if (rd_ready[0] !== 1'b0) begin
            failures++; $display("FAIL l2_ready_e1 got=%b exp=0", rd_ready[0]);
        end
        tick();                                   // E2 -> RESP
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_error[0] !== 1'b0 || rd_data[0] !== 32'h0000_0013) begin
            failures++;
            $display("FAIL l2_resp got rdy=%b err=%b data=%h exp rdy=1 err=0 data=00000013",
                     rd_ready[0], rd_error[0], rd_data[0]);
        end
        rd_en[0] = 1'b0;
        tick();                                   // E3 -> IDLE
        checks++;
        if (rd_ready[0] !== 1'b0 || rd_data[0] !== 32'h0) begin
            failures++;
            $display("FAIL l2_after got rdy=%b data=%h exp rdy=0 data=0", rd_ready[0], rd_data[0]);
        end
    endtask

    task automatic test_latency0();
        do_write(1, 32'h0, 32'hDEAD_BEEF);
        issue(1, 32'h0, 1);                       // capture and RESP on same edge
        checks++;
        if (rd_ready[1] !== 1'b1 || rd_data[1] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL l0_resp got rdy=%b data=%h exp rdy=1 data=deadbeef", rd_ready[1], rd_data[1]);
        end
        tick();                                   // enable still high, RESP -> IDLE
        checks++;
        if (rd_ready[1] !== 1'b0 || rd_data[1] !== 32'h0) begin
            failures++;
            $display("FAIL l0_gap got rdy=%b data=%h exp rdy=0 data=0", rd_ready[1], rd_data[1]);
        end
        tick();                                   // second request accepted
        checks++;
        if (rd_ready[1] !== 1'b1 || rd_data[1] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL l0_second got rdy=%b data=%h exp rdy=1 data=deadbeef", rd_ready[1], rd_data[1]);
        end
        rd_en[1] = 1'b0;
        tick();
        checks++;
        if (rd_ready[1] !== 1'b0) begin
            failures++; $display("FAIL l0_idle got=%b exp=0", rd_ready[1]);
        end
    endtask

    task automatic test_errors();
        do_write(0, 32'h0, 32'hCAFE_F00D);
        do_write(0, 32'h40, 32'h5555_5555);       // index 16 >= DEPTH: dropped
        issue(0, 32'h2, 3);
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_error[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
            failures++;
            $display("FAIL err_misaligned got rdy=%b err=%b data=%h exp rdy=1 err=1 data=0",
                     rd_ready[0], rd_error[0], rd_data[0]);
        end
        rd_en[0] = 1'b0;
        tick();
        checks++;
        if (rd_error[0] !== 1'b0) begin
            failures++; $display("FAIL err_clears got=%b exp=0", rd_error[0]);
        end
        issue(0, 32'h40, 3);
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_error[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
            failures++;
            $display("FAIL err_range got rdy=%b err=%b data=%h exp rdy=1 err=1 data=0",
                     rd_ready[0], rd_error[0], rd_data[0]);
        end
        rd_en[0] = 1'b0;
        tick();
        issue(0, 32'h3C, 3);                      // last valid word, unwritten: only error matters
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_error[0] !== 1'b0) begin
            failures++;
            $display("FAIL err_lastword got rdy=%b err=%b exp rdy=1 err=0", rd_ready[0], rd_error[0]);
        end
        rd_en[0] = 1'b0;
        tick();
        issue(0, 32'h0, 3);
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_error[0] !== 1'b0 || rd_data[0] !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL err_dropwrite got rdy=%b err=%b data=%h exp rdy=1 err=0 data=cafef00d",
                     rd_ready[0], rd_error[0], rd_data[0]);
        end
        rd_en[0] = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int pulses;
        do_write(2, 32'h8, 32'h1234_5678);
        do_write(2, 32'h4, 32'h0BAD_F00D);
        issue(2, 32'h4, 1);                       // captured, WAIT
        rd_en[2] = 1'b0;
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += int'(rd_ready[2]);
        end
        checks++;
        if (pulses != 0) begin
            failures++; $display("FAIL abort_pulses got=%0d exp=0", pulses);
        end
        issue(2, 32'h8, 1);                       // E0
        rd_addr[2] = 32'h4;                       // ignored while waiting
        tick();                                   // E1
        tick();                                   // E2
        checks++;
        if (rd_ready[2] !== 1'b0) begin
            failures++; $display("FAIL l3_early got=%b exp=0", rd_ready[2]);
        end
        tick();                                   // E3 -> RESP
        checks++;
        if (rd_ready[2] !== 1'b1 || rd_error[2] !== 1'b0 || rd_data[2] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL l3_resp got rdy=%b err=%b data=%h exp rdy=1 err=0 data=12345678",
                     rd_ready[2], rd_error[2], rd_data[2]);
        end
        rd_en[2] = 1'b0;
        tick();
    endtask

    task automatic test_reset_wait();
        int pulses;
        // Reset while waiting: nothing may follow release.
        issue(0, 32'h4, 2);                       // E0, E1: still WAIT
        #2 reset = 1'b1;
        rd_en[0] = 1'b0;
        #1 reset = 1'b0;
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += int'(rd_ready[0]);
        end
        checks++;
        if (pulses != 0) begin
            failures++; $display("FAIL rst_wait_pulses got=%0d exp=0", pulses);
        end
        // Reset in the RESP cycle clears outputs without waiting for an edge.
        issue(0, 32'h4, 3);
        checks++;
        if (rd_ready[0] !== 1'b1) begin
            failures++; $display("FAIL rst_pre_resp got=%b exp=1", rd_ready[0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (rd_ready[0] !== 1'b0 || rd_data[0] !== 32'h0 || rd_error[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got rdy=%b err=%b data=%h exp all 0",
                     rd_ready[0], rd_error[0], rd_data[0]);
        end
        // Request already present as reset drops: accepted on the first edge.
        rd_addr[0] = 32'h4;
        rd_en[0]   = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_data[0] !== 32'h0000_0013) begin
            failures++;
            $display("FAIL rst_first_req got rdy=%b data=%h exp rdy=1 data=00000013",
                     rd_ready[0], rd_data[0]);
        end
        rd_en[0] = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back_rbw();
        issue(0, 32'h4, 2);                       // E0, E1
        wr_en[0]   = 1'b1;
        wr_addr[0] = 32'h5;                       // low bits ignored: word 1
        wr_data[0] = 32'h1111_1111;
        tick();                                   // E2: RESP entry + write
        wr_en[0] = 1'b0;
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_data[0] !== 32'h0000_0013) begin
            failures++;
            $display("FAIL rbw_old got rdy=%b data=%h exp rdy=1 data=00000013", rd_ready[0], rd_data[0]);
        end
        rd_en[0] = 1'b0;
        tick();
        issue(0, 32'h4, 3);
        checks++;
        if (rd_ready[0] !== 1'b1 || rd_data[0] !== 32'h1111_1111) begin
            failures++;
            $display("FAIL rbw_new got rdy=%b data=%h exp rdy=1 data=11111111", rd_ready[0], rd_data[0]);
        end
        rd_en[0] = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        rd_en = '0;
        wr_en = '0;
        for (int k = 0; k < 3; k++) begin
            rd_addr[k] = '0;
            wr_addr[k] = '0;
            wr_data[k] = '0;
        end
        #23;
        test_reset();
        test_latency2();
        test_latency0();
        test_errors();
        test_abort();
        test_reset_wait();
        test_back_to_back_rbw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
